// File: rtl/wb_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
// State encoding and master identifiers.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle.
// MASTER drives the request side, SLAVE answers.
interface wishbone #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic [XLEN/8-1:0] sel;
  logic              we;
  logic              stb;
  logic              cyc;
  logic              ack;

  modport MASTER (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack
  );

  modport SLAVE (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_arbiter_watchdog.sv
// Wait-for-ACK counter of the granted transfer.
// Fires on the last allowed cycle; TIMEOUT=0 disables it.
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  assign expire = (TIMEOUT != 0) && en
                  && (cnt_q == LAST);

  // Count stalled cycles; restart on any completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (TIMEOUT == 0 || clr || expire) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter for the core memory port.
// Per-transfer round-robin grant with a hang watchdog.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  wishbone.SLAVE   ifu_bus,
  wishbone.SLAVE   lsu_bus,
  wishbone.MASTER  mem_bus,
  output logic     gnt_i,
  output logic     gnt_d,
  output logic     timeout,
  output logic     timeout_d
);

  arb_state        state_q, state_d;
  logic            last_q, last_d;
  logic            req_i, req_d;
  logic            sel_d, granted;
  logic            own_req, oth_req;
  logic            wd_en, wd_clr, expire;
  logic            done;
  logic [XLEN-1:0] rdat;

  assign req_i   = ifu_bus.cyc & ifu_bus.stb;
  assign req_d   = lsu_bus.cyc & lsu_bus.stb;
  assign gnt_i   = (state_q == GNT_I);
  assign gnt_d   = (state_q == GNT_D);
  assign granted = gnt_i | gnt_d;
  assign sel_d   = gnt_d;
  assign own_req = sel_d ? req_d : req_i;
  assign oth_req = sel_d ? req_i : req_d;

  assign wd_en  = granted & own_req & ~mem_bus.ack;
  assign done   = granted & own_req
                  & (mem_bus.ack | expire);
  assign wd_clr = done | ~granted
                  | (state_d != state_q);

  assign timeout   = expire;
  assign timeout_d = expire & sel_d;
  assign rdat      = expire ? '0 : mem_bus.dat_r;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wd_en),
    .clr   (wd_clr),
    .expire(expire)
  );

  // Grant state and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= MST_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Grant decision: switch only on a finished transfer.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = (last_q == MST_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
          state_d = GNT_I;
        end else if (req_d) begin
          state_d = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (done && oth_req) begin
          state_d = sel_d ? GNT_I : GNT_D;
          last_d  = sel_d ? MST_D : MST_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus steering toward the granted master.
  always_comb begin
    mem_bus.adr   = '0;
    mem_bus.dat_w = '0;
    mem_bus.sel   = '0;
    mem_bus.we    = 1'b0;
    mem_bus.stb   = 1'b0;
    mem_bus.cyc   = 1'b0;
    ifu_bus.ack   = 1'b0;
    ifu_bus.dat_r = '0;
    lsu_bus.ack   = 1'b0;
    lsu_bus.dat_r = '0;
    unique case (1'b1)
      gnt_i: begin
        mem_bus.adr   = ifu_bus.adr;
        mem_bus.dat_w = ifu_bus.dat_w;
        mem_bus.sel   = ifu_bus.sel;
        mem_bus.we    = ifu_bus.we;
        mem_bus.stb   = ifu_bus.stb & ~expire;
        mem_bus.cyc   = ifu_bus.cyc & ~expire;
        ifu_bus.ack   = mem_bus.ack | expire;
        ifu_bus.dat_r = rdat;
      end
      gnt_d: begin
        mem_bus.adr   = lsu_bus.adr;
        mem_bus.dat_w = lsu_bus.dat_w;
        mem_bus.sel   = lsu_bus.sel;
        mem_bus.we    = lsu_bus.we;
        mem_bus.stb   = lsu_bus.stb & ~expire;
        mem_bus.cyc   = lsu_bus.cyc & ~expire;
        lsu_bus.ack   = mem_bus.ack | expire;
        lsu_bus.dat_r = rdat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expectations queued per master,
// a negedge monitor checks every ACK the DUT returns.
module tb_wb_arbiter;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    bit          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gnt_i, gnt_d, timeout, timeout_d;
  logic hang = 1'b0;
  logic ack_q;
  logic [31:0] dq;
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_i[$];
  exp_t exp_d[$];
  bit   log_m[$];
  int   log_c[$];

  wishbone #(.XLEN(32)) ifu_if ();
  wishbone #(.XLEN(32)) lsu_if ();
  wishbone #(.XLEN(32)) mem_if ();

  wb_arbiter #(
    .XLEN   (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifu_bus  (ifu_if),
    .lsu_bus  (lsu_if),
    .mem_bus  (mem_if),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d),
    .timeout  (timeout),
    .timeout_d(timeout_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model: registered ACK, data = ~address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dq    <= '0;
    end else begin
      ack_q <= mem_if.stb & mem_if.cyc
               & ~ack_q & ~hang;
      dq    <= ~mem_if.adr;
    end
  end

  assign mem_if.ack   = ack_q;
  assign mem_if.dat_r = ack_q ? dq : '0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic mon(input bit m);
    exp_t e;
    logic [31:0] d;
    checks++;
    if ((m ? exp_d.size() : exp_i.size()) == 0) begin
      errors++;
      $display("FAIL unexp_ack: master %0d got 1 expected 0",
               m);
      return;
    end
    e = m ? exp_d.pop_front() : exp_i.pop_front();
    d = m ? lsu_if.dat_r : ifu_if.dat_r;
    chk("dat_r", d, e.dat);
    chk("timeout", timeout, e.to);
    if (e.to) begin
      chk("timeout_d", timeout_d, m);
      chk("to_stb", mem_if.stb, 0);
    end else begin
      chk("mem_adr", mem_if.adr, e.adr);
      chk("mem_we", mem_if.we, e.we);
      chk("mem_stb", mem_if.stb, 1);
    end
    log_m.push_back(m);
    log_c.push_back(cyc_n);
  endtask

  // Monitor: every presented ACK is checked.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("gnt_excl", gnt_i & gnt_d, 0);
      if (ifu_if.ack) mon(0);
      if (lsu_if.ack) mon(1);
      if (!ifu_if.ack && !lsu_if.ack)
        chk("stray_to", timeout, 0);
    end
  end

  task automatic drive(input bit m, input logic s,
                       input logic [31:0] a,
                       input logic w);
    if (m) begin
      lsu_if.adr = a; lsu_if.dat_w = a ^ 32'h1;
      lsu_if.sel = 4'hF; lsu_if.we = w;
      lsu_if.stb = s; lsu_if.cyc = s;
    end else begin
      ifu_if.adr = a; ifu_if.dat_w = a ^ 32'h1;
      ifu_if.sel = 4'hF; ifu_if.we = w;
      ifu_if.stb = s; ifu_if.cyc = s;
    end
  endtask

  task automatic xfer(input bit m,
                      input logic [31:0] a,
                      input logic w, input bit keep,
                      input bit to, output int n);
    exp_t e;
    logic ak;
    e.adr = a; e.we = w; e.to = to;
    e.dat = to ? 32'h0 : ~a;
    if (m) exp_d.push_back(e);
    else   exp_i.push_back(e);
    drive(m, 1'b1, a, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ak = m ? lsu_if.ack : ifu_if.ack;
    end while (!ak && n < 64);
    if (!ak) chk("ack_wait", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) drive(m, 1'b0, a, w);
  endtask

  task automatic stream(input bit m,
                        input logic [31:0] base,
                        input int cnt, input logic w);
    int n;
    for (int i = 0; i < cnt; i++)
      xfer(m, base + 32'(i * 4), w,
           i < cnt - 1, 0, n);
  endtask

  task automatic chk_log(input string nm,
                         input string pat);
    bit em;
    chk({nm, "_len"}, log_m.size(), pat.len());
    for (int i = 0; i < pat.len() && i < log_m.size();
         i++) begin
      em = (pat[i] == "D");
      chk({nm, "_order"}, log_m[i], em);
      if (i > 0)
        chk({nm, "_gap"}, log_c[i] - log_c[i-1], 2);
    end
    log_m.delete();
    log_c.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'hDEAD_0000, 1'b1);
    drive(1, 1'b0, 32'hBEEF_0000, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_m.delete();
    log_c.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not end");
    $fatal(1);
  end

  initial begin
    int n;
    // 1: reset with idle masters
    rst_n = 1'b0;
    drive(0, 1'b0, 32'hDEAD_0000, 1'b1);
    drive(1, 1'b0, 32'hBEEF_0000, 1'b1);
    @(negedge clk);
    chk("rst_stb", mem_if.stb, 0);
    chk("rst_cyc", mem_if.cyc, 0);
    chk("rst_we", mem_if.we, 0);
    chk("rst_adr", mem_if.adr, 0);
    chk("rst_datw", mem_if.dat_w, 0);
    chk("rst_sel", mem_if.sel, 0);
    chk("rst_gnt", {gnt_i, gnt_d}, 0);
    chk("rst_to", {timeout, timeout_d}, 0);
    chk("rst_ack", {ifu_if.ack, lsu_if.ack}, 0);
    chk("rst_datr_i", ifu_if.dat_r, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: single fetch, latency
    fork
      xfer(0, 32'h0000_0100, 1'b0, 0, 0, n);
      begin
        @(negedge clk);
        chk("t2_gnt0", gnt_i, 0);
        @(negedge clk);
        chk("t2_gnt1", gnt_i, 1);
        chk("t2_adr", mem_if.adr, 32'h0000_0100);
      end
    join
    chk("t2_lat", n, 3);
    log_m.delete();
    log_c.delete();

    // 3: D cuts into an I stream
    fork
      stream(0, 32'h0000_0200, 4, 1'b0);
      begin
        int k, n2;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!gnt_i && k < 20);
        #1 xfer(1, 32'h2000_0040, 1'b1, 0, 0, n2);
      end
    join
    chk_log("t3", "IDIII");

    // 4: tie out of reset, strict alternation
    do_reset();
    fork
      stream(0, 32'h0000_1000, 4, 1'b0);
      stream(1, 32'h2000_2000, 4, 1'b1);
    join
    chk_log("t4", "IDIDIDID");

    // 5: watchdog on a hung D transfer
    do_reset();
    hang = 1'b1;
    xfer(1, 32'h2000_0080, 1'b0, 0, 1, n);
    chk("t5_cycles", n, 5);
    @(negedge clk);
    chk("t5_pulse", timeout, 0);
    @(negedge clk);
    chk("t5_idle", {gnt_i, gnt_d}, 0);
    log_m.delete();
    log_c.delete();

    // 6: async reset while D waits
    do_reset();
    drive(1, 1'b1, 32'h2000_00C0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_gnt", gnt_d, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_stb", mem_if.stb, 0);
    chk("t6_cyc", mem_if.cyc, 0);
    chk("t6_gnt_d", gnt_d, 0);
    hang = 1'b0;
    drive(1, 1'b0, 32'h2000_00C0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    log_m.delete();
    log_c.delete();
    fork
      xfer(0, 32'h0000_0300, 1'b0, 0, 0, n);
      begin
        int n3;
        xfer(1, 32'h2000_0400, 1'b1, 0, 0, n3);
      end
    join
    chk_log("t6", "ID");

    repeat (3) @(negedge clk);
    chk("exp_i_left", exp_i.size(), 0);
    chk("exp_d_left", exp_d.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
